// File: rtl/matrix_col_scanner_if.sv
// Bus between the column scanner and the row path / demux.
// The bright input exists only when MATRIX_SCAN_DIM_EN is defined.
interface matrix_col_scanner_if #(
  parameter int NUM_COLS = 5
);
  logic                en;
  logic [2:0]          sel;
  logic [NUM_COLS-1:0] col_en;
  logic                blank;
  logic                frame_start;
`ifdef MATRIX_SCAN_DIM_EN
  logic [2:0]          bright;

  modport master (input en, input bright, output sel, output col_en, output blank, output frame_start);
  modport slave  (output en, output bright, input sel, input col_en, input blank, input frame_start);
`else
  modport master (input en, output sel, output col_en, output blank, output frame_start);
  modport slave  (output en, input sel, input col_en, input blank, input frame_start);
`endif
endinterface

// File: rtl/matrix_col_scanner.sv
// Column-scan sequencer for the LED matrix: IDLE/BLANK/DRIVE cycle with registered
// select, one-hot column enables and frame pulse. Optional dimming: MATRIX_SCAN_DIM_EN.
module matrix_col_scanner #(
  parameter int NUM_COLS     = 5,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  matrix_col_scanner_if.master bus
);

  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
  localparam logic [2:0]    SEL_LAST   = 3'(NUM_COLS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BLANK = 2'd1, DRIVE = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          sel_q, sel_d;
  logic [NUM_COLS-1:0] col_en_q, col_en_d;
  logic                blank_q, blank_d;
  logic                frame_start_q, frame_start_d;
  logic                drive_entry_s;
  logic                lit_s;

`ifdef MATRIX_SCAN_DIM_EN
  logic [CW-1:0]       on_q, on_d;

  function automatic logic [CW-1:0] on_cycles(input logic [2:0] b);
    int t;
    t = (DWELL_CYCLES * (int'(b) + 1)) >> 3;
    if (t < 1) begin
      t = 1;
    end else begin
      t = t;
    end
    return CW'(t);
  endfunction
`endif

  // Next-state, counter and output computation; outputs are registered from these.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        cnt_d = {CW{1'b0}};
        sel_d = 3'd0;
        if (BLANK_CYCLES == 0) begin
          state_d = DRIVE;
        end else begin
          state_d = BLANK;
        end
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = DRIVE;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRIVE: begin
        if (cnt_q == DWELL_LAST) begin
          sel_d = (sel_q == SEL_LAST) ? 3'd0 : (sel_q + 3'd1);
          cnt_d = {CW{1'b0}};
          if (BLANK_CYCLES == 0) begin
            state_d = DRIVE;
          end else begin
            state_d = BLANK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
        sel_d   = 3'd0;
      end
    endcase

    // en low overrides everything and parks the scanner at column 0.
    if (!bus.en) begin
      state_d = IDLE;
      cnt_d   = {CW{1'b0}};
      sel_d   = 3'd0;
    end else begin
      state_d = state_d;
    end

    drive_entry_s = (state_d == DRIVE) && (cnt_d == {CW{1'b0}});
`ifdef MATRIX_SCAN_DIM_EN
    if (drive_entry_s) begin
      on_d = on_cycles(bus.bright);
    end else begin
      on_d = on_q;
    end
    lit_s = (state_d == DRIVE) && (cnt_d < on_d);
`else
    lit_s = (state_d == DRIVE);
`endif

    if (lit_s) begin
      col_en_d = NUM_COLS'(1) << sel_d;
    end else begin
      col_en_d = {NUM_COLS{1'b0}};
    end
    blank_d       = !lit_s;
    frame_start_d = drive_entry_s && (sel_d == 3'd0);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= {CW{1'b0}};
      sel_q         <= 3'd0;
      col_en_q      <= {NUM_COLS{1'b0}};
      blank_q       <= 1'b1;
      frame_start_q <= 1'b0;
`ifdef MATRIX_SCAN_DIM_EN
      on_q          <= {CW{1'b0}};
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sel_q         <= sel_d;
      col_en_q      <= col_en_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
`ifdef MATRIX_SCAN_DIM_EN
      on_q          <= on_d;
`endif
    end
  end

  assign bus.sel         = sel_q;
  assign bus.col_en      = col_en_q;
  assign bus.blank       = blank_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_matrix_col_scanner.sv
// Directed self-checking bench for matrix_col_scanner (5 cols, dwell 4, blank 2/0;
// dimming instance with dwell 16 when MATRIX_SCAN_DIM_EN is defined).
module tb_matrix_col_scanner;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  matrix_col_scanner_if #(.NUM_COLS(5)) bus0 ();
  matrix_col_scanner_if #(.NUM_COLS(5)) bus1 ();

  matrix_col_scanner #(.NUM_COLS(5), .DWELL_CYCLES(4), .BLANK_CYCLES(2)) u0 (
    .clk(clk), .rst(rst), .bus(bus0));
  matrix_col_scanner #(.NUM_COLS(5), .DWELL_CYCLES(4), .BLANK_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .bus(bus1));

`ifdef MATRIX_SCAN_DIM_EN
  matrix_col_scanner_if #(.NUM_COLS(5)) bus2 ();
  matrix_col_scanner #(.NUM_COLS(5), .DWELL_CYCLES(16), .BLANK_CYCLES(2)) u2 (
    .clk(clk), .rst(rst), .bus(bus2));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset and raise en on bus0; returns on the first DRIVE cycle of column 0.
  task automatic start_scan0();
    rst = 1'b1;
    bus0.en = 1'b0;
    #2;
    rst = 1'b0;
    tick();
    bus0.en = 1'b1;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    rst = 1'b1;
    bus0.en = 1'b0;
    bus1.en = 1'b0;
    #3;
    obs = {bus0.sel, bus0.col_en, bus0.blank, bus0.frame_start};
    n_checks++;
    if (obs !== 10'b000_00000_1_0) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", obs, 10'b000_00000_1_0);
    end
    tick();
    obs = {bus1.sel, bus1.col_en, bus1.blank, bus1.frame_start};
    n_checks++;
    if (obs !== 10'b000_00000_1_0) begin
      n_fail++;
      $display("FAIL reset_state_noblank: got %b expected %b", obs, 10'b000_00000_1_0);
    end
    rst = 1'b0;
  endtask

  task automatic test_first_column();
    logic [9:0] obs;
    logic [9:0] exp_v [0:7];
    exp_v[0] = 10'b000_00000_1_0;
    exp_v[1] = 10'b000_00000_1_0;
    exp_v[2] = 10'b000_00001_0_1;
    exp_v[3] = 10'b000_00001_0_0;
    exp_v[4] = 10'b000_00001_0_0;
    exp_v[5] = 10'b000_00001_0_0;
    exp_v[6] = 10'b001_00000_1_0;
    exp_v[7] = 10'b001_00000_1_0;
    rst = 1'b1;
    bus0.en = 1'b0;
    #2;
    rst = 1'b0;
    tick();
    bus0.en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      obs = {bus0.sel, bus0.col_en, bus0.blank, bus0.frame_start};
      n_checks++;
      if (obs !== exp_v[i]) begin
        n_fail++;
        $display("FAIL first_column cyc%0d: got %b expected %b", i, obs, exp_v[i]);
      end
    end
  endtask

  task automatic test_frames();
    logic [9:0] obs;
    logic [9:0] expv;
    logic [2:0] prev_sel;
    int p, c, w;
    logic [2:0] es;
    logic [4:0] ec;
    logic [4:0] one;
    start_scan0();
    prev_sel = 3'd0;
    one = 5'b00001;
    for (int k = 0; k < 60; k++) begin
      p = k % 30;
      c = p / 6;
      w = p % 6;
      es = (w < 4) ? 3'(c) : 3'((c + 1) % 5);
      ec = (w < 4) ? (one << c) : 5'b00000;
      expv = {es, ec, (w >= 4), (p == 0)};
      obs = {bus0.sel, bus0.col_en, bus0.blank, bus0.frame_start};
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL frames k%0d: got %b expected %b", k, obs, expv);
      end
      if (bus0.sel !== prev_sel) begin
        n_checks++;
        if (bus0.col_en !== 5'b00000) begin
          n_fail++;
          $display("FAIL sel_change_lit k%0d: col_en %b expected %b", k, bus0.col_en, 5'b00000);
        end
      end
      prev_sel = bus0.sel;
      tick();
    end
  endtask

  task automatic test_en_drop();
    logic [9:0] obs;
    start_scan0();
    repeat (19) tick();
    obs = {bus0.sel, bus0.col_en, bus0.blank, bus0.frame_start};
    n_checks++;
    if (obs !== 10'b011_01000_0_0) begin
      n_fail++;
      $display("FAIL en_drop_pre: got %b expected %b", obs, 10'b011_01000_0_0);
    end
    bus0.en = 1'b0;
    tick();
    obs = {bus0.sel, bus0.col_en, bus0.blank, bus0.frame_start};
    n_checks++;
    if (obs !== 10'b000_00000_1_0) begin
      n_fail++;
      $display("FAIL en_drop_idle: got %b expected %b", obs, 10'b000_00000_1_0);
    end
    tick();
    tick();
    bus0.en = 1'b1;
    tick();
    tick();
    obs = {bus0.sel, bus0.col_en, bus0.blank, bus0.frame_start};
    n_checks++;
    if (obs !== 10'b000_00000_1_0) begin
      n_fail++;
      $display("FAIL en_restart_blank: got %b expected %b", obs, 10'b000_00000_1_0);
    end
    tick();
    obs = {bus0.sel, bus0.col_en, bus0.blank, bus0.frame_start};
    n_checks++;
    if (obs !== 10'b000_00001_0_1) begin
      n_fail++;
      $display("FAIL en_restart_drive: got %b expected %b", obs, 10'b000_00001_0_1);
    end
  endtask

  task automatic test_async_reset();
    logic [9:0] obs;
    start_scan0();
    repeat (13) tick();
    obs = {bus0.sel, bus0.col_en, bus0.blank, bus0.frame_start};
    n_checks++;
    if (obs !== 10'b010_00100_0_0) begin
      n_fail++;
      $display("FAIL async_rst_pre: got %b expected %b", obs, 10'b010_00100_0_0);
    end
    #1;
    rst = 1'b1;
    #1;
    obs = {bus0.sel, bus0.col_en, bus0.blank, bus0.frame_start};
    n_checks++;
    if (obs !== 10'b000_00000_1_0) begin
      n_fail++;
      $display("FAIL async_rst_now: got %b expected %b", obs, 10'b000_00000_1_0);
    end
    rst = 1'b0;
    tick();
    tick();
    obs = {bus0.sel, bus0.col_en, bus0.blank, bus0.frame_start};
    n_checks++;
    if (obs !== 10'b000_00000_1_0) begin
      n_fail++;
      $display("FAIL async_rst_blank: got %b expected %b", obs, 10'b000_00000_1_0);
    end
    tick();
    obs = {bus0.sel, bus0.col_en, bus0.blank, bus0.frame_start};
    n_checks++;
    if (obs !== 10'b000_00001_0_1) begin
      n_fail++;
      $display("FAIL async_rst_resume: got %b expected %b", obs, 10'b000_00001_0_1);
    end
    bus0.en = 1'b0;
  endtask

  task automatic test_no_blank();
    logic [9:0] obs;
    logic [9:0] expv;
    logic [4:0] one;
    int c;
    one = 5'b00001;
    rst = 1'b1;
    bus1.en = 1'b0;
    #2;
    rst = 1'b0;
    tick();
    bus1.en = 1'b1;
    tick();
    for (int k = 0; k < 40; k++) begin
      c = (k / 4) % 5;
      expv = {3'(c), (one << c), 1'b0, (k % 20 == 0)};
      obs = {bus1.sel, bus1.col_en, bus1.blank, bus1.frame_start};
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL no_blank k%0d: got %b expected %b", k, obs, expv);
      end
      tick();
    end
    bus1.en = 1'b0;
  endtask

`ifdef MATRIX_SCAN_DIM_EN
  task automatic test_dimming(input logic [2:0] br, input int on_exp);
    logic [9:0] obs;
    logic [9:0] expv;
    logic [4:0] one;
    logic       lit;
    int c, w;
    one = 5'b00001;
    rst = 1'b1;
    bus2.en = 1'b0;
    bus2.bright = br;
    #2;
    rst = 1'b0;
    tick();
    bus2.en = 1'b1;
    tick();
    tick();
    tick();
    for (int k = 0; k < 36; k++) begin
      c = k / 18;
      w = k % 18;
      lit = (w < on_exp);
      expv = {((w < 16) ? 3'(c) : 3'(c + 1)), (lit ? (one << c) : 5'b00000), !lit, (k == 0)};
      obs = {bus2.sel, bus2.col_en, bus2.blank, bus2.frame_start};
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL dim_b%0d k%0d: got %b expected %b", br, k, obs, expv);
      end
      tick();
    end
    bus2.en = 1'b0;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus0.en  = 1'b0;
    bus1.en  = 1'b0;
`ifdef MATRIX_SCAN_DIM_EN
    bus0.bright = 3'd7;
    bus1.bright = 3'd7;
    bus2.bright = 3'd7;
    bus2.en     = 1'b0;
`endif
    test_reset();
    test_first_column();
    test_frames();
    test_en_drop();
    test_async_reset();
    test_no_blank();
`ifdef MATRIX_SCAN_DIM_EN
    test_dimming(3'd3, 8);
    test_dimming(3'd0, 2);
    test_dimming(3'd7, 16);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
